rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
Sequences the register file and shares its single write port between two writeback requesters: A (ALU/F1 results) and B (memory/F2 results).
Runs the register-file clear and R0-init sequence after reset or on restart.
Buffers each requester in a small FIFO and arbitrates one write per cycle.
Exports a per-register pending mask so decode can stall on in-flight writes.

Parameters:
REG_COUNT, 16, number of architectural registers (from shared constants)
REG_SIZE, 8, register data width
REG_PTR_SIZE, 4, register index width
FIFO_DEPTH, 2, entries per requester FIFO (power of two, >=2)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
restart  in  1  single-cycle pulse: drain, then re-run clear/init sequence
r0_init_value  in  REG_SIZE  value loaded into R0 during INIT (e.g. core id)
a_valid  in  1  requester A has a write
a_ready  out  1  A FIFO can accept
a_dst  in  REG_PTR_SIZE  A destination register
a_data  in  REG_SIZE  A write data
b_valid  in  1  requester B has a write
b_ready  out  1  B FIFO can accept
b_dst  in  REG_PTR_SIZE  B destination register
b_data  in  REG_SIZE  B write data
rf_reset  out  1  drives register-file synchronous clear
rf_init_r0  out  1  drives register-file R0 init enable
rf_init_r0_data  out  REG_SIZE  R0 init data
rf_wr_en  out  1  write-port enable
rf_wr_ptr  out  REG_PTR_SIZE  write-port index
rf_wr_data  out  REG_SIZE  write-port data
pending_mask  out  REG_COUNT  bit i set if any buffered entry targets register i
seq_done  out  1  high in RUN

Behaviour:
- Reset values (async, reset_n low): FSM=CLR, both FIFOs empty, rr pointer=A, all outputs 0 except rf_reset=1.
- FSM states:
  - CLR: 1 cycle; rf_reset=1.
  - INIT: 1 cycle; rf_init_r0=1, rf_init_r0_data=r0_init_value.
  - RUN: normal operation; seq_done=1.
  - DRAIN: entered from RUN when restart=1; moves to CLR when both FIFOs are empty.
- Transitions: CLR->INIT->RUN. restart outside RUN is ignored.
- Handshake: a_ready/b_ready = (state==RUN) & (count<FIFO_DEPTH). Push occurs on valid&ready.
  - Ready depends only on registered count: no push into a full FIFO even if it pops the same cycle.
- Arbitration: each cycle in RUN or DRAIN, at most one non-empty head is popped and drives rf_wr_* (registered outputs).
  - Latency: push in cycle N reaches rf_wr_en at the earliest in cycle N+2 (FIFO write N, grant N+1, RF write edge at end of N+1 via registered output).
  - rf_wr_en=0 when both FIFOs are empty or state is CLR/INIT.
- Arbitration policy: round-robin (grant alternates when both are non-empty; the pointer moves to the other requester after each grant). Non-RR build: see Optional Feature.
- Ordering: per-requester order is preserved. Same-register writes from A and B are committed in grant order. Decode must stall on pending_mask to avoid WAW/RAW across requesters.
- pending_mask: combinational OR of decoded dst over all valid FIFO entries plus the registered output stage when rf_wr_en=1.
  - Pushes are not reflected until the cycle after acceptance.
- Simultaneous events: push and pop of the same FIFO in one cycle are both performed and count is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: all buffered writes are discarded and the sequence restarts at CLR.

Optional Feature:
RF_WB_RR_EN
- Defined: round-robin arbitration as above.
- Undefined: fixed priority, A always wins when non-empty. The rr pointer register is removed.

Decomposition:
- Shared package/constants header: REG_COUNT, REG_SIZE, REG_PTR_SIZE; FSM state encoding (CLR=0, INIT=1, RUN=2, DRAIN=3); FIFO_DEPTH default.
- One sub-module: wb_fifo (parameterised sync FIFO with count, push/pop, entry-valid/dst vectors exposed for pending_mask). Instantiated twice.

Test Plan:
- Release reset_n, r0_init_value=8'h05 -> cycle 1 rf_reset=1, cycle 2 rf_init_r0=1 with data 8'h05, cycle 3 seq_done=1, a_ready=b_ready=1.
- A pushes (dst 3, 8'hAA) alone -> rf_wr_en=1, ptr 3, data 8'hAA two cycles later. pending_mask[3]=1 from the cycle after the push until the write cycle.
- A and B both hold 2 entries (A: r1,r2; B: r4,r5), RR build -> write order r1,r4,r2,r5. Without RF_WB_RR_EN -> r1,r2,r4,r5.
- Fill A to FIFO_DEPTH with no grants possible -> a_ready=0. Extra a_valid is held off; no entry lost or duplicated.
- restart with 1 entry queued -> a_ready=b_ready=0, the entry is written, then CLR, INIT, RUN.
- Assert reset_n low while both FIFOs are non-empty -> no further rf_wr_en, pending_mask=0, sequence restarts at CLR.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared register-file constants and sequencer state encoding
package rf_wb_arbiter_pkg;
  localparam int REG_COUNT      = 16;
  localparam int REG_SIZE       = 8;
  localparam int REG_PTR_SIZE   = 4;
  localparam int FIFO_DEPTH_DEF = 2;

  typedef enum logic [1:0] {
    ST_CLR   = 2'd0,
    ST_INIT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } wb_state_t;
endpackage

// File: rtl/rf_wb_arbiter_fifo.sv
// rtl/rf_wb_arbiter_fifo.sv - wb_fifo: small sync FIFO exposing per-entry valid/dst for hazard tracking
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 8,
  parameter int PW    = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                push,
  input  logic [PW-1:0]       push_dst,
  input  logic [DW-1:0]       push_data,
  input  logic                pop,
  output logic [CW-1:0]       count,
  output logic [PW-1:0]       head_dst,
  output logic [DW-1:0]       head_data,
  output logic [DEPTH-1:0]    entry_valid,
  output logic [DEPTH*PW-1:0] entry_dst
);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] mem_dst  [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_dst[wr_ptr]  <= push_dst;
      mem_data[wr_ptr] <= push_data;
    end
  end

  assign head_dst  = mem_dst[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  always_comb begin
    logic [AW-1:0] off;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr;
      entry_valid[i] = {1'b0, off} < count;
      entry_dst[i*PW +: PW] = mem_dst[i];
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file clear/init sequencer and two-requester writeback arbiter
// RF_WB_RR_EN selects round-robin arbitration; undefined gives fixed priority to requester A.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    restart,
  input  logic [REG_SIZE-1:0]     r0_init_value,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [REG_PTR_SIZE-1:0] a_dst,
  input  logic [REG_SIZE-1:0]     a_data,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [REG_PTR_SIZE-1:0] b_dst,
  input  logic [REG_SIZE-1:0]     b_data,
  output logic                    rf_reset,
  output logic                    rf_init_r0,
  output logic [REG_SIZE-1:0]     rf_init_r0_data,
  output logic                    rf_wr_en,
  output logic [REG_PTR_SIZE-1:0] rf_wr_ptr,
  output logic [REG_SIZE-1:0]     rf_wr_data,
  output logic [REG_COUNT-1:0]    pending_mask,
  output logic                    seq_done
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wb_state_t state, state_nxt;
  logic [CW-1:0]                      a_count, b_count;
  logic [REG_PTR_SIZE-1:0]            a_head_dst, b_head_dst;
  logic [REG_SIZE-1:0]                a_head_data, b_head_data;
  logic [FIFO_DEPTH-1:0]              a_entry_valid, b_entry_valid;
  logic [FIFO_DEPTH*REG_PTR_SIZE-1:0] a_entry_dst, b_entry_dst;
  logic a_push, b_push, grant_a, grant_b, arb_en, a_nonempty, b_nonempty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_CLR;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLR:   state_nxt = ST_INIT;
      ST_INIT:  state_nxt = ST_RUN;
      ST_RUN:   if (restart) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!a_nonempty && !b_nonempty) state_nxt = ST_CLR;
      default:  state_nxt = ST_CLR;
    endcase
  end

  // Ready looks only at the registered count, so a full FIFO never takes a push even while popping.
  always_comb begin
    rf_reset        = (state == ST_CLR);
    rf_init_r0      = (state == ST_INIT);
    rf_init_r0_data = (state == ST_INIT) ? r0_init_value : '0;
    seq_done        = (state == ST_RUN);
    a_ready         = (state == ST_RUN) && (a_count < CW'(FIFO_DEPTH));
    b_ready         = (state == ST_RUN) && (b_count < CW'(FIFO_DEPTH));
  end

  assign a_push     = a_valid && a_ready;
  assign b_push     = b_valid && b_ready;
  assign a_nonempty = (a_count != '0);
  assign b_nonempty = (b_count != '0);
  assign arb_en     = (state == ST_RUN) || (state == ST_DRAIN);

`ifdef RF_WB_RR_EN
  logic rr_b;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     rr_b <= 1'b0;
    else if (grant_a) rr_b <= 1'b1;
    else if (grant_b) rr_b <= 1'b0;
  end
  assign grant_a = arb_en && a_nonempty && (!b_nonempty || !rr_b);
`else
  assign grant_a = arb_en && a_nonempty;
`endif
  assign grant_b = arb_en && b_nonempty && !grant_a;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_wr_en   <= 1'b0;
      rf_wr_ptr  <= '0;
      rf_wr_data <= '0;
    end else begin
      rf_wr_en <= grant_a || grant_b;
      if (grant_a) begin
        rf_wr_ptr  <= a_head_dst;
        rf_wr_data <= a_head_data;
      end else if (grant_b) begin
        rf_wr_ptr  <= b_head_dst;
        rf_wr_data <= b_head_data;
      end
    end
  end

  // The output stage still counts as in flight until the register file has taken it.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (a_entry_valid[i]) pending_mask[a_entry_dst[i*REG_PTR_SIZE +: REG_PTR_SIZE]] = 1'b1;
      if (b_entry_valid[i]) pending_mask[b_entry_dst[i*REG_PTR_SIZE +: REG_PTR_SIZE]] = 1'b1;
    end
    if (rf_wr_en) pending_mask[rf_wr_ptr] = 1'b1;
  end

  wb_fifo #(.DEPTH(FIFO_DEPTH), .DW(REG_SIZE), .PW(REG_PTR_SIZE)) u_fifo_a (
    .clk(clk), .reset_n(reset_n), .push(a_push), .push_dst(a_dst), .push_data(a_data),
    .pop(grant_a), .count(a_count), .head_dst(a_head_dst), .head_data(a_head_data),
    .entry_valid(a_entry_valid), .entry_dst(a_entry_dst)
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH), .DW(REG_SIZE), .PW(REG_PTR_SIZE)) u_fifo_b (
    .clk(clk), .reset_n(reset_n), .push(b_push), .push_dst(b_dst), .push_data(b_data),
    .pop(grant_b), .count(b_count), .head_dst(b_head_dst), .head_data(b_head_data),
    .entry_valid(b_entry_valid), .entry_dst(b_entry_dst)
  );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - randomized bench for rf_wb_arbiter against a queue-based reference model
module tb_rf_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int M_CLR = 0, M_INIT = 1, M_RUN = 2, M_DRAIN = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic restart = 1'b0;
  logic [7:0] r0_init_value = 8'h05;
  logic a_valid = 1'b0, b_valid = 1'b0;
  logic [3:0] a_dst = '0, b_dst = '0;
  logic [7:0] a_data = '0, b_data = '0;
  logic a_ready, b_ready, rf_reset, rf_init_r0, rf_wr_en, seq_done;
  logic [7:0] rf_init_r0_data, rf_wr_data;
  logic [3:0] rf_wr_ptr;
  logic [15:0] pending_mask;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .restart(restart), .r0_init_value(r0_init_value),
    .a_valid(a_valid), .a_ready(a_ready), .a_dst(a_dst), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_dst(b_dst), .b_data(b_data),
    .rf_reset(rf_reset), .rf_init_r0(rf_init_r0), .rf_init_r0_data(rf_init_r0_data),
    .rf_wr_en(rf_wr_en), .rf_wr_ptr(rf_wr_ptr), .rf_wr_data(rf_wr_data),
    .pending_mask(pending_mask), .seq_done(seq_done)
  );

  typedef struct {
    logic [3:0] dst;
    logic [7:0] data;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  int   mst;
  bit   m_en;
  bit   m_rr_b;
  logic [3:0] m_ptr;
  logic [7:0] m_data;
  logic [3:0] wr_log[$];
  bit   saw_full;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    mst = M_CLR;
    m_en = 1'b0;
    m_rr_b = 1'b0;
    m_ptr = '0;
    m_data = '0;
  endtask

  task automatic check_outputs();
    logic [15:0] exp_mask;
    exp_mask = '0;
    foreach (qa[i]) exp_mask[qa[i].dst] = 1'b1;
    foreach (qb[i]) exp_mask[qb[i].dst] = 1'b1;
    if (m_en) exp_mask[m_ptr] = 1'b1;
    chk("rf_reset", rf_reset, mst == M_CLR);
    chk("rf_init_r0", rf_init_r0, mst == M_INIT);
    chk("rf_init_r0_data", rf_init_r0_data, (mst == M_INIT) ? r0_init_value : 8'h00);
    chk("seq_done", seq_done, mst == M_RUN);
    chk("a_ready", a_ready, (mst == M_RUN) && (qa.size() < DEPTH));
    chk("b_ready", b_ready, (mst == M_RUN) && (qb.size() < DEPTH));
    chk("rf_wr_en", rf_wr_en, m_en);
    if (m_en) begin
      chk("rf_wr_ptr", rf_wr_ptr, m_ptr);
      chk("rf_wr_data", rf_wr_data, m_data);
    end
    chk("pending_mask", pending_mask, exp_mask);
  endtask

  // Called at a negedge: check the current cycle, drive inputs, advance the model, move to next negedge.
  task automatic step(input bit av, input logic [3:0] ad, input logic [7:0] adt,
                      input bit bv, input logic [3:0] bd, input logic [7:0] bdt, input bit rs);
    bit pa, pb, ga, gb, both_empty;
    ent_t e;
    check_outputs();
    if (rf_wr_en) wr_log.push_back(rf_wr_ptr);
    if (seq_done && (!a_ready || !b_ready)) saw_full = 1'b1;
    a_valid = av; a_dst = ad; a_data = adt;
    b_valid = bv; b_dst = bd; b_data = bdt;
    restart = rs;

    pa = av && (mst == M_RUN) && (qa.size() < DEPTH);
    pb = bv && (mst == M_RUN) && (qb.size() < DEPTH);
    both_empty = (qa.size() == 0) && (qb.size() == 0);
    ga = 1'b0;
    gb = 1'b0;
    if (mst == M_RUN || mst == M_DRAIN) begin
`ifdef RF_WB_RR_EN
      if (qa.size() > 0 && (qb.size() == 0 || !m_rr_b)) ga = 1'b1;
      else if (qb.size() > 0) gb = 1'b1;
`else
      if (qa.size() > 0) ga = 1'b1;
      else if (qb.size() > 0) gb = 1'b1;
`endif
    end
    m_en = ga || gb;
    if (ga) begin
      e = qa.pop_front(); m_ptr = e.dst; m_data = e.data; m_rr_b = 1'b1;
    end else if (gb) begin
      e = qb.pop_front(); m_ptr = e.dst; m_data = e.data; m_rr_b = 1'b0;
    end
    case (mst)
      M_CLR:   mst = M_INIT;
      M_INIT:  mst = M_RUN;
      M_RUN:   if (rs) mst = M_DRAIN;
      default: if (both_empty) mst = M_CLR;
    endcase
    if (pa) begin e.dst = ad; e.data = adt; qa.push_back(e); end
    if (pb) begin e.dst = bd; e.data = bdt; qb.push_back(e); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    restart = 1'b0;
    model_reset();
    #1;
    chk("rst_rf_wr_en", rf_wr_en, 1'b0);
    chk("rst_pending_mask", pending_mask, 16'h0000);
    chk("rst_rf_reset", rf_reset, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_order [4];
`ifdef RF_WB_RR_EN
    exp_order = '{4'd1, 4'd4, 4'd2, 4'd5};
`else
    exp_order = '{4'd1, 4'd2, 4'd4, 4'd5};
`endif
    model_reset();
    saw_full = 1'b0;
    @(negedge clk);
    do_reset();

    // bring-up: CLR, INIT with R0 value, then RUN
    idle(1);
    chk("init_r0", rf_init_r0, 1'b1);
    chk("init_r0_data", rf_init_r0_data, 8'h05);
    idle(1);
    chk("run_seq_done", seq_done, 1'b1);
    chk("run_a_ready", a_ready, 1'b1);
    chk("run_b_ready", b_ready, 1'b1);

    // both requesters hold two entries
    wr_log.delete();
    step(1'b1, 4'd1, 8'h11, 1'b1, 4'd4, 8'h44, 1'b0);
    step(1'b1, 4'd2, 8'h22, 1'b1, 4'd5, 8'h55, 1'b0);
    idle(5);
    chk("order_count", wr_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < wr_log.size()) chk($sformatf("order_%0d", i), wr_log[i], exp_order[i]);

    // single A write, two-cycle latency, pending until written
    step(1'b1, 4'd3, 8'hAA, 1'b0, 4'd0, 8'h00, 1'b0);
    chk("pend3_next", pending_mask[3], 1'b1);
    chk("lat_not_yet", rf_wr_en, 1'b0);
    idle(1);
    chk("lat_wr_en", rf_wr_en, 1'b1);
    chk("lat_wr_ptr", rf_wr_ptr, 4'd3);
    chk("lat_wr_data", rf_wr_data, 8'hAA);
    chk("pend3_write", pending_mask[3], 1'b1);
    idle(2);

    // saturate both requesters so one FIFO fills
    saw_full = 1'b0;
    for (int i = 0; i < 6; i++)
      step(1'b1, 4'($urandom_range(0, 15)), 8'($urandom), 1'b1, 4'($urandom_range(0, 15)), 8'($urandom), 1'b0);
    chk("fifo_full_seen", saw_full, 1'b1);
    idle(5);

    // restart with one entry queued
    step(1'b1, 4'd7, 8'h77, 1'b0, 4'd0, 8'h00, 1'b1);
    chk("drain_a_ready", a_ready, 1'b0);
    chk("drain_b_ready", b_ready, 1'b0);
    idle(6);
    chk("restart_back_run", seq_done, 1'b1);

    // reset while both FIFOs hold data
    step(1'b1, 4'd9, 8'h99, 1'b1, 4'd10, 8'hBB, 1'b0);
    do_reset();
    idle(3);

    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        r0_init_value = 8'($urandom);
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), 8'($urandom),
             $urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), 8'($urandom),
             $urandom_range(0, 39) == 0);
      end
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
